// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// This block is the instruction-fetch stage and the F/D pipeline register
// that sits in front of the opcode decode/control unit. It owns the PC,
// drives the instruction-memory word address, and latches the fetched
// instruction together with its PC and PC+1.
//
// After reset the stage runs a short BOOT phase. During BOOT it fetches
// nothing and loads only bubbles into F/D. It then enters RUN, which only
// reset can leave.
//
// In RUN the update priority at each edge is:
//   1. redirect   - a downstream redirect (taken branch or jr)
//   2. stall      - the hazard unit freezes PC, F/D and the counter
//   3. early jump - j/jal jump straight to their target with no bubble
//   4. sequential - PC advances by one
//
// Ports
//   clock          : rising-edge clock
//   reset          : synchronous, active-high reset
//   address_imem   : instruction-memory word address, pc[ADDR_W-1:0] (combinational)
//   q_imem         : instruction word at address_imem
//   stall          : hold PC and F/D
//   redirect_valid : downstream control-flow redirect
//   redirect_pc    : redirect target PC
//   fd_insn        : latched instruction (0 when the entry is a bubble)
//   fd_pc          : PC of fd_insn
//   fd_pc_plus1    : fd_pc + 1 (jal link value / branch base)
//   fd_valid       : F/D holds a real instruction
//   fetch_count    : number of instructions accepted into F/D (wraps)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int          ADDR_W      = 12,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BOOT_CYCLES = 2,
  parameter bit          EARLY_JUMP  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] address_imem,
  input  logic [31:0]       q_imem,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       fd_insn,
  output logic [31:0]       fd_pc,
  output logic [31:0]       fd_pc_plus1,
  output logic              fd_valid,
  output logic [31:0]       fetch_count
);

  // BOOT_CYCLES must be in the range 1..15. Out-of-range values are clamped
  // here so that the 4-bit boot counter can always reach its terminal value.
  localparam int BOOT_N = (BOOT_CYCLES < 1)  ? 1  :
                          (BOOT_CYCLES > 15) ? 15 : BOOT_CYCLES;
  localparam logic [3:0] BOOT_LAST = BOOT_N[3:0];

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_JAL = 5'b00011;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [0:0]  state_q,    state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] fd_insn_q,  fd_insn_d;
  logic [31:0] fd_pc_q,    fd_pc_d;
  logic [31:0] fd_pc1_q,   fd_pc1_d;
  logic        fd_valid_q, fd_valid_d;
  logic [31:0] fcount_q,   fcount_d;

  // -------------------------------------------------------------------------
  // Fetch-side decode
  // -------------------------------------------------------------------------
  logic [31:0] pc_plus1;
  logic        is_jump;
  logic [31:0] jump_target;

  // Wraps naturally at 2^32.
  assign pc_plus1 = pc_q + 32'd1;

  // Only j/jal are resolved here. Every other opcode, including jr and the
  // branches, is fetched sequentially and corrected later by a redirect.
  assign is_jump     = EARLY_JUMP &&
                       ((q_imem[31:27] == OP_J) || (q_imem[31:27] == OP_JAL));
  assign jump_target = {5'b0, q_imem[26:0]};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    fd_insn_d  = fd_insn_q;
    fd_pc_d    = fd_pc_q;
    fd_pc1_d   = fd_pc1_q;
    fd_valid_d = fd_valid_q;
    fcount_d   = fcount_q;

    case (state_q)
      ST_BOOT: begin
        // Stall and redirect are ignored while booting. F/D is forced to a
        // bubble, and fd_pc/fd_pc_plus1 keep their reset values.
        pc_d       = RESET_PC;
        fd_insn_d  = 32'd0;
        fd_valid_d = 1'b0;
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_d == BOOT_LAST) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (redirect_valid) begin
          // The redirect comes from an older instruction that is already
          // downstream. Whatever sits in F/D is therefore wrong-path and is
          // flushed, even if it was being held by a stall.
          pc_d       = redirect_pc;
          fd_insn_d  = 32'd0;
          fd_valid_d = 1'b0;
        end else if (stall) begin
          // Hold everything.
        end else begin
          fd_insn_d  = q_imem;
          fd_pc_d    = pc_q;
          fd_pc1_d   = pc_plus1;
          fd_valid_d = 1'b1;
          fcount_d   = fcount_q + 32'd1;
          // A jal still travels down the pipe so decode can write its link
          // value; only the next fetch address changes.
          pc_d       = is_jump ? jump_target : pc_plus1;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= 4'd0;
      pc_q       <= RESET_PC;
      fd_insn_q  <= 32'd0;
      fd_pc_q    <= 32'd0;
      fd_pc1_q   <= 32'd0;
      fd_valid_q <= 1'b0;
      fcount_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      fd_insn_q  <= fd_insn_d;
      fd_pc_q    <= fd_pc_d;
      fd_pc1_q   <= fd_pc1_d;
      fd_valid_q <= fd_valid_d;
      fcount_q   <= fcount_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign address_imem = pc_q[ADDR_W-1:0];
  assign fd_insn      = fd_insn_q;
  assign fd_pc        = fd_pc_q;
  assign fd_pc_plus1  = fd_pc1_q;
  assign fd_valid     = fd_valid_q;
  assign fetch_count  = fcount_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage. Two instances share every control input:
// u1 has EARLY_JUMP=1 and u0 has EARLY_JUMP=0. Each instance reads its own
// port of a shared ROM model.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_pc;

  logic [11:0] a1, a0;
  logic [31:0] q1, q0;
  logic [31:0] fd_insn1, fd_pc1, fd_pc_plus1_1, fetch_count1;
  logic [31:0] fd_insn0, fd_pc0, fd_pc_plus1_0, fetch_count0;
  logic        fd_valid1, fd_valid0;

  logic [31:0] rom [0:4095];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  assign q1 = rom[a1];
  assign q0 = rom[a0];

  fetch_stage #(.ADDR_W(12), .RESET_PC(32'h0), .BOOT_CYCLES(2), .EARLY_JUMP(1'b1)) u1 (
    .clock(clock), .reset(reset), .address_imem(a1), .q_imem(q1),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fd_insn(fd_insn1), .fd_pc(fd_pc1), .fd_pc_plus1(fd_pc_plus1_1),
    .fd_valid(fd_valid1), .fetch_count(fetch_count1));

  fetch_stage #(.ADDR_W(12), .RESET_PC(32'h0), .BOOT_CYCLES(2), .EARLY_JUMP(1'b0)) u0 (
    .clock(clock), .reset(reset), .address_imem(a0), .q_imem(q0),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fd_insn(fd_insn0), .fd_pc(fd_pc0), .fd_pc_plus1(fd_pc_plus1_0),
    .fd_valid(fd_valid0), .fetch_count(fetch_count0));

  // -------------------------------------------------------------------------
  // Behavioural reference: architectural state plus the number of boot
  // cycles still to run.
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] fpc;
    logic [31:0] fpc1;
    logic        valid;
    logic [31:0] cnt;
    logic [3:0]  boot_left;
  } model_t;

  model_t m1, m0;

  function automatic model_t step(model_t m, bit early, bit rst, bit stl, bit rv,
                                  logic [31:0] rpc);
    model_t      n;
    logic [31:0] q;
    q = rom[m.pc[11:0]];
    n = m;
    if (rst) begin
      n           = '0;
      n.boot_left = 4'd2;
    end else if (m.boot_left != 0) begin
      n.boot_left = m.boot_left - 4'd1;
      n.insn      = 0;
      n.valid     = 0;
    end else if (rv) begin
      n.pc    = rpc;
      n.insn  = 0;
      n.valid = 0;
    end else if (!stl) begin
      n.insn  = q;
      n.fpc   = m.pc;
      n.fpc1  = m.pc + 1;
      n.valid = 1;
      n.cnt   = m.cnt + 1;
      if (early && (q[31:27] == 5'd1 || q[31:27] == 5'd3)) n.pc = {5'b0, q[26:0]};
      else                                                 n.pc = m.pc + 1;
    end
    return n;
  endfunction

  function automatic logic [140:0] mvec(model_t m);
    return {m.pc[11:0], m.insn, m.fpc, m.fpc1, m.valid, m.cnt};
  endfunction

  function automatic logic [140:0] dvec1();
    return {a1, fd_insn1, fd_pc1, fd_pc_plus1_1, fd_valid1, fetch_count1};
  endfunction

  function automatic logic [140:0] dvec0();
    return {a0, fd_insn0, fd_pc0, fd_pc_plus1_0, fd_valid0, fetch_count0};
  endfunction

  function automatic logic [31:0] plain_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:27] == 5'd1 || w[31:27] == 5'd3) w[31:27] = 5'b00101;
    return w;
  endfunction

  function automatic logic [31:0] mk_jump(bit link, logic [26:0] tgt);
    return {(link ? 5'b00011 : 5'b00001), tgt};
  endfunction

  // Advance the reference and the DUTs by one edge. Outputs are sampled on
  // the following falling edge.
  task automatic tick();
    m1 = step(m1, 1'b1, reset, stall, redirect_valid, redirect_pc);
    m0 = step(m0, 1'b0, reset, stall, redirect_valid, redirect_pc);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_redirect(logic [31:0] tgt);
    redirect_valid = 1; redirect_pc = tgt;
    tick();
    redirect_valid = 0; redirect_pc = 0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < 16; i++) rom[i] = plain_word();
    reset = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
    tick(); tick();
    checks++;
    if ({a1, fd_insn1, fd_pc1, fd_pc_plus1_1, fd_valid1, fetch_count1} !== 141'd0) begin
      failures++;
      $display("FAIL reset_state: got %h want 0",
               {a1, fd_insn1, fd_pc1, fd_pc_plus1_1, fd_valid1, fetch_count1});
    end
    reset = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (dvec1() !== mvec(m1) || dvec0() !== mvec(m0)) begin
        failures++;
        $display("FAIL boot_model c=%0d: got %h / %h want %h / %h",
                 c, dvec1(), dvec0(), mvec(m1), mvec(m0));
      end
      checks++;
      if (c < 2) begin
        if (fd_valid1 !== 1'b0 || a1 !== 12'd0) begin
          failures++;
          $display("FAIL boot_bubble c=%0d: got valid=%b addr=%h want valid=0 addr=0",
                   c, fd_valid1, a1);
        end
      end else begin
        if (fd_valid1 !== 1'b1 || fd_pc1 !== 32'(c-2) || fd_pc_plus1_1 !== 32'(c-1) ||
            fetch_count1 !== 32'(c-1)) begin
          failures++;
          $display("FAIL boot_seq c=%0d: got v=%b pc=%h pc1=%h cnt=%0d want v=1 pc=%0d pc1=%0d cnt=%0d",
                   c, fd_valid1, fd_pc1, fd_pc_plus1_1, fetch_count1, c-2, c-1, c-1);
        end
      end
    end
  endtask

  task automatic test_jump();
    rom[5] = mk_jump(1'b0, 27'h40); rom[6] = plain_word(); rom[32'h40] = plain_word();
    do_redirect(32'd5);
    tick();
    checks++;
    if (fd_insn1 !== rom[5] || fd_pc1 !== 32'd5 || a1 !== 12'h040 || a0 !== 12'd6) begin
      failures++;
      $display("FAIL j_entry: got insn=%h pc=%h a1=%h a0=%h want insn=%h pc=5 a1=040 a0=006",
               fd_insn1, fd_pc1, a1, a0, rom[5]);
    end
    tick();
    checks++;
    if (fd_pc1 !== 32'h40 || fd_valid1 !== 1'b1 || fd_pc0 !== 32'd6 || fd_valid0 !== 1'b1) begin
      failures++;
      $display("FAIL j_next: got pc1=%h v1=%b pc0=%h v0=%b want 40 1 6 1",
               fd_pc1, fd_valid1, fd_pc0, fd_valid0);
    end
  endtask

  task automatic test_jal();
    rom[7] = mk_jump(1'b1, 27'h123); rom[8] = plain_word(); rom[32'h123] = plain_word();
    do_redirect(32'd7);
    tick();
    checks++;
    if (fd_insn1 !== rom[7] || fd_pc1 !== 32'd7 || fd_pc_plus1_1 !== 32'd8 ||
        a1 !== 12'h123 || a0 !== 12'd8) begin
      failures++;
      $display("FAIL jal_entry: got insn=%h pc=%h pc1=%h a1=%h a0=%h want %h 7 8 123 008",
               fd_insn1, fd_pc1, fd_pc_plus1_1, a1, a0, rom[7]);
    end
  endtask

  task automatic test_stall();
    logic [31:0] cnt;
    rom[9] = plain_word(); rom[10] = plain_word();
    do_redirect(32'd9);
    tick();
    cnt = fetch_count1;
    stall = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (a1 !== 12'd10 || fd_pc1 !== 32'd9 || fd_valid1 !== 1'b1 || fetch_count1 !== cnt) begin
        failures++;
        $display("FAIL stall_hold c=%0d: got a=%h pc=%h v=%b cnt=%0d want a=00a pc=9 v=1 cnt=%0d",
                 c, a1, fd_pc1, fd_valid1, fetch_count1, cnt);
      end
    end
    stall = 0;
    tick();
    checks++;
    if (fd_pc1 !== 32'd10 || fd_insn1 !== rom[10] || fetch_count1 !== cnt + 1) begin
      failures++;
      $display("FAIL stall_release: got pc=%h insn=%h cnt=%0d want pc=a insn=%h cnt=%0d",
               fd_pc1, fd_insn1, fetch_count1, rom[10], cnt + 1);
    end
  endtask

  task automatic test_redirect_stall();
    logic [31:0] cnt;
    rom[32'h30] = mk_jump(1'b0, 27'h99); rom[32'h20] = plain_word();
    do_redirect(32'h30);
    cnt = fetch_count1;
    stall = 1; redirect_valid = 1; redirect_pc = 32'h20;
    tick();
    stall = 0; redirect_valid = 0;
    checks++;
    if (a1 !== 12'h020 || fd_valid1 !== 1'b0 || fd_insn1 !== 32'd0 || fetch_count1 !== cnt) begin
      failures++;
      $display("FAIL redir_stall: got a=%h v=%b insn=%h cnt=%0d want a=020 v=0 insn=0 cnt=%0d",
               a1, fd_valid1, fd_insn1, fetch_count1, cnt);
    end
    tick();
    checks++;
    if (fd_pc1 !== 32'h20 || fd_valid1 !== 1'b1 || a1 !== 12'h021 || fetch_count1 !== cnt + 1) begin
      failures++;
      $display("FAIL redir_target: got pc=%h v=%b a=%h cnt=%0d want pc=20 v=1 a=021 cnt=%0d",
               fd_pc1, fd_valid1, a1, fetch_count1, cnt + 1);
    end
  endtask

  task automatic test_wrap();
    rom[12'hFFF] = plain_word(); rom[0] = plain_word();
    do_redirect(32'hFFF);
    tick();
    checks++;
    if (fd_pc1 !== 32'hFFF || fd_pc_plus1_1 !== 32'h1000 || a1 !== 12'h000) begin
      failures++;
      $display("FAIL addr_wrap: got pc=%h pc1=%h a=%h want fff 1000 000", fd_pc1, fd_pc_plus1_1, a1);
    end
    do_redirect(32'hFFFF_FFFF);
    tick();
    checks++;
    if (fd_pc1 !== 32'hFFFF_FFFF || fd_pc_plus1_1 !== 32'd0 || a1 !== 12'h000) begin
      failures++;
      $display("FAIL pc_wrap: got pc=%h pc1=%h a=%h want ffffffff 0 000", fd_pc1, fd_pc_plus1_1, a1);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1; stall = 1; redirect_valid = 1; redirect_pc = 32'h55;
    tick();
    reset = 0;
    checks++;
    if (a1 !== 12'd0 || fd_valid1 !== 1'b0 || fetch_count1 !== 32'd0 || fd_insn1 !== 32'd0 ||
        fd_pc1 !== 32'd0 || fd_pc_plus1_1 !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: got a=%h v=%b cnt=%0d insn=%h pc=%h pc1=%h want all 0",
               a1, fd_valid1, fetch_count1, fd_insn1, fd_pc1, fd_pc_plus1_1);
    end
    // Boot ignores both stall and redirect.
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (a1 !== 12'd0 || fd_valid1 !== 1'b0) begin
        failures++;
        $display("FAIL boot_ignore c=%0d: got a=%h v=%b want 0 0", c, a1, fd_valid1);
      end
    end
    stall = 0; redirect_valid = 0;
    tick();
    checks++;
    if (fd_pc1 !== 32'd0 || fd_valid1 !== 1'b1 || fetch_count1 !== 32'd1) begin
      failures++;
      $display("FAIL reboot_first: got pc=%h v=%b cnt=%0d want 0 1 1", fd_pc1, fd_valid1, fetch_count1);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 4096; i++)
      rom[i] = ($urandom_range(0, 9) == 0) ? mk_jump($urandom_range(0, 1) == 1, 27'($urandom))
                                           : plain_word();
    for (int c = 0; c < 600; c++) begin
      reset          = ($urandom_range(0, 99) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4095));
      tick();
      checks++;
      if (dvec1() !== mvec(m1) || dvec0() !== mvec(m0)) begin
        failures++;
        bad++;
        if (bad <= 5)
          $display("FAIL random c=%0d: got %h / %h want %h / %h",
                   c, dvec1(), dvec0(), mvec(m1), mvec(m0));
      end
    end
    reset = 0; stall = 0; redirect_valid = 0;
  endtask

  initial begin
    m1 = '0; m0 = '0;
    test_reset();
    test_jump();
    test_jal();
    test_stall();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
